// File: rtl/nios_custom_dma_copy_ctrl.sv
// -----------------------------------------------------------------------------
// nios_custom_dma_copy_ctrl
//
// Word-copy sequencer: streams LEN words from a single-port source RAM to a
// single-port destination RAM at one word per clock, programmed through a
// four-register Avalon-MM CSR slave, with a level completion interrupt.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   csr_*               Avalon-MM slave (0=SRC, 1=DST, 2=LEN, 3=CTRL/STATUS),
//                       zero wait states, combinational readback
//   irq                 done & irq_en
//   src_*               source RAM port (read data valid one cycle after address)
//   dst_*               destination RAM port (write data passes straight from src)
// -----------------------------------------------------------------------------
module nios_custom_dma_copy_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    // CSR slave
    input  logic [1:0]          csr_address,
    input  logic                csr_write,
    input  logic                csr_read,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    output logic                irq,
    // Source RAM
    output logic [ADDR_W-1:0]   src_address,
    output logic                src_chipselect,
    input  logic [DATA_W-1:0]   src_readdata,
    // Destination RAM
    output logic [ADDR_W-1:0]   dst_address,
    output logic                dst_chipselect,
    output logic                dst_write,
    output logic [DATA_W/8-1:0] dst_byteenable,
    output logic [DATA_W-1:0]   dst_writedata
);

    localparam int unsigned LenW = ADDR_W + 1;
    // Largest transfer: the whole RAM.
    localparam logic [LenW-1:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LenW-1:0]   len_q;
    logic              irq_en_q;
    logic              done_q;
    logic              aborted_q;
    logic              abort_seen_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [LenW-1:0]   remaining_q;
    logic              wr_en_q;

    logic              ctrl_wr;
    logic              start_cmd;
    logic              abort_cmd;
    logic              clear_cmd;
    logic              busy;
    logic              go;
    logic [LenW-1:0]   len_clamped;
    logic              unused_wdata;

    assign ctrl_wr   = csr_write && (csr_address == 2'd3);
    assign start_cmd = ctrl_wr && csr_writedata[0];
    assign abort_cmd = ctrl_wr && csr_writedata[1];
    assign clear_cmd = ctrl_wr && csr_writedata[3];

    // FINISH with done already set (normal end) is no longer busy; FINISH on
    // the LEN=0 path is still busy until done appears the following cycle.
    assign busy = (state_q != StIdle) && !done_q;
    assign go   = start_cmd && !busy;

    assign len_clamped = (len_q > MaxLen) ? MaxLen : len_q;

    assign unused_wdata = ^csr_writedata[31:LenW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            remaining_q  <= '0;
            wr_en_q      <= 1'b0;
        end else begin
            // Every read issued in RUN becomes a write one cycle later.
            wr_en_q <= (state_q == StRun);
            if (wr_en_q) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end

            if (ctrl_wr) begin
                irq_en_q <= csr_writedata[2];
            end

            if (csr_write && !busy) begin
                case (csr_address)
                    2'd0:    src_q <= csr_writedata[ADDR_W-1:0];
                    2'd1:    dst_q <= csr_writedata[ADDR_W-1:0];
                    2'd2:    len_q <= csr_writedata[LenW-1:0];
                    default: ;
                endcase
            end

            if (clear_cmd) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end

            unique case (state_q)
                StIdle, StFinish: begin
                    if (state_q == StFinish) begin
                        state_q <= StIdle;
                        // LEN=0 path arrives here with done still clear.
                        if (!done_q) begin
                            done_q <= 1'b1;
                        end
                    end
                    if (go) begin
                        done_q       <= 1'b0;
                        aborted_q    <= 1'b0;
                        abort_seen_q <= 1'b0;
                        rd_ptr_q     <= src_q;
                        wr_ptr_q     <= dst_q;
                        remaining_q  <= len_clamped;
                        state_q      <= (len_q == '0) ? StFinish : StRun;
                    end
                end
                StRun: begin
                    rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - LenW'(1);
                    if (abort_cmd) begin
                        abort_seen_q <= 1'b1;
                    end
                    if (remaining_q == LenW'(1) || abort_cmd) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // The last pending write retires this cycle.
                    done_q    <= 1'b1;
                    aborted_q <= abort_seen_q;
                    state_q   <= StFinish;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign src_chipselect = (state_q == StRun);
    assign src_address    = rd_ptr_q;
    assign dst_write      = wr_en_q;
    assign dst_chipselect = wr_en_q;
    assign dst_address    = wr_ptr_q;
    assign dst_byteenable = wr_en_q ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
    assign dst_writedata  = src_readdata;
    assign irq            = done_q && irq_en_q;

    always_comb begin
        csr_readdata = '0;
        if (csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata[ADDR_W-1:0] = src_q;
                2'd1:    csr_readdata[ADDR_W-1:0] = dst_q;
                2'd2:    csr_readdata[LenW-1:0]   = len_q;
                default: csr_readdata[3:0]        = {aborted_q, irq_en_q, done_q, busy};
            endcase
        end
    end

endmodule
